// File: rtl/efpga_pad_pkg.sv
// Shared constants for the eFPGA pad-ring controller: register word addresses,
// reset patterns and the set of lock-protected registers.
package efpga_pad_pkg;

  localparam int unsigned DATA_W = 32;

  localparam int unsigned REG_OWNER       = 0;
  localparam int unsigned REG_CPU_OUT     = 1;
  localparam int unsigned REG_CPU_OE      = 2;
  localparam int unsigned REG_IE          = 3;
  localparam int unsigned REG_PE          = 4;
  localparam int unsigned REG_DS          = 5;
  localparam int unsigned REG_IRQ_RISE_EN = 6;
  localparam int unsigned REG_IRQ_FALL_EN = 7;
  localparam int unsigned REG_IRQ_STATUS  = 8;
  localparam int unsigned REG_PAD_IN      = 9;
  localparam int unsigned REG_LOCK        = 10;

  localparam logic [DATA_W-1:0] RST_ZERO    = 32'h0000_0000;
  localparam logic [DATA_W-1:0] RST_PAD_CFG = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] LOCK_SET_MASK = 32'h0000_0001;

  // Registers frozen once LOCK is set; data-path and irq registers stay live.
  function automatic logic is_lock_protected(input logic [DATA_W-1:0] addr);
    return (addr == DATA_W'(REG_OWNER)) || (addr == DATA_W'(REG_IE)) ||
           (addr == DATA_W'(REG_PE))    || (addr == DATA_W'(REG_DS)) ||
           (addr == DATA_W'(REG_LOCK));
  endfunction

endpackage

// File: rtl/pad_sync_edge.sv
// Multi-stage synchroniser for pad inputs with rise/fall detection; edges are
// masked until the chain has flushed its reset contents after reset release.
module pad_sync_edge #(
  parameter int unsigned NUM_PADS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_PADS-1:0] pad_c,
  output logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] rise,
  output logic [NUM_PADS-1:0] fall
);

  localparam int unsigned WARM  = SYNC_STAGES + 1;
  localparam int unsigned CNT_W = $clog2(WARM + 1);

  logic [NUM_PADS-1:0] stage [SYNC_STAGES];
  logic [NUM_PADS-1:0] last_q;
  logic [CNT_W-1:0]    warm_cnt;
  logic                armed;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage[i] <= '0;
      last_q   <= '0;
      warm_cnt <= '0;
    end else begin
      stage[0] <= pad_c;
      for (int i = 1; i < int'(SYNC_STAGES); i++) stage[i] <= stage[i-1];
      last_q <= stage[SYNC_STAGES-1];
      if (warm_cnt != CNT_W'(WARM)) warm_cnt <= warm_cnt + CNT_W'(1);
    end
  end

  assign armed  = (warm_cnt == CNT_W'(WARM));
  assign pad_in = stage[SYNC_STAGES-1];
  assign rise   = armed ? (stage[SYNC_STAGES-1] & ~last_q) : '0;
  assign fall   = armed ? (~stage[SYNC_STAGES-1] & last_q) : '0;

endmodule

// File: rtl/efpga_pad_ctrl.sv
// Pad-ring controller: CPU register file, registered read port, per-pad
// ownership mux between eFPGA fabric and CPU, and edge interrupt logic.
module efpga_pad_ctrl
  import efpga_pad_pkg::*;
#(
  parameter int unsigned NUM_PADS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic                CLK,
  input  logic                resetn,
  input  logic [NUM_PADS-1:0] I_top,
  input  logic [NUM_PADS-1:0] T_top,
  output logic [NUM_PADS-1:0] O_top,
  input  logic [NUM_PADS-1:0] pad_C,
  output logic [NUM_PADS-1:0] pad_I,
  output logic [NUM_PADS-1:0] pad_OEN,
  output logic [NUM_PADS-1:0] pad_IE,
  output logic [NUM_PADS-1:0] pad_PE,
  output logic [NUM_PADS-1:0] pad_DS,
  input  logic                WriteStrobe,
  input  logic [ADDR_W-1:0]   WriteAddr,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic                ReadStrobe,
  input  logic [ADDR_W-1:0]   ReadAddr,
  output logic [DATA_W-1:0]   ReadData,
  output logic                ReadValid,
  output logic                irq
);

  logic [NUM_PADS-1:0] owner, cpu_out, cpu_oe, ie, pe, ds;
  logic [NUM_PADS-1:0] rise_en, fall_en, status, status_next;
  logic [NUM_PADS-1:0] pad_in, rise, fall, wdata, w1c;
  logic                lock;
  logic [DATA_W-1:0]   waddr, raddr, rd_word;
  logic                unused_wdata;

  assign waddr        = DATA_W'(WriteAddr);
  assign raddr        = DATA_W'(ReadAddr);
  assign wdata        = WriteData[NUM_PADS-1:0];
  assign unused_wdata = ^WriteData;

  pad_sync_edge #(
    .NUM_PADS    (NUM_PADS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (CLK),
    .resetn (resetn),
    .pad_c  (pad_C),
    .pad_in (pad_in),
    .rise   (rise),
    .fall   (fall)
  );

  // A new edge wins over a same-cycle write-1-to-clear of that bit.
  always_comb begin
    w1c = '0;
    if (WriteStrobe && (waddr == DATA_W'(REG_IRQ_STATUS))) w1c = wdata;
    status_next = (status & ~w1c) | (rise & rise_en) | (fall & fall_en);
  end

  always_comb begin
    rd_word = '0;
    case (raddr)
      DATA_W'(REG_OWNER):       rd_word = DATA_W'(owner);
      DATA_W'(REG_CPU_OUT):     rd_word = DATA_W'(cpu_out);
      DATA_W'(REG_CPU_OE):      rd_word = DATA_W'(cpu_oe);
      DATA_W'(REG_IE):          rd_word = DATA_W'(ie);
      DATA_W'(REG_PE):          rd_word = DATA_W'(pe);
      DATA_W'(REG_DS):          rd_word = DATA_W'(ds);
      DATA_W'(REG_IRQ_RISE_EN): rd_word = DATA_W'(rise_en);
      DATA_W'(REG_IRQ_FALL_EN): rd_word = DATA_W'(fall_en);
      DATA_W'(REG_IRQ_STATUS):  rd_word = DATA_W'(status);
      DATA_W'(REG_PAD_IN):      rd_word = DATA_W'(pad_in);
      DATA_W'(REG_LOCK):        rd_word = DATA_W'(lock);
      default:                  rd_word = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      owner     <= NUM_PADS'(RST_ZERO);
      cpu_out   <= NUM_PADS'(RST_ZERO);
      cpu_oe    <= NUM_PADS'(RST_ZERO);
      ie        <= NUM_PADS'(RST_PAD_CFG);
      pe        <= NUM_PADS'(RST_PAD_CFG);
      ds        <= NUM_PADS'(RST_PAD_CFG);
      rise_en   <= NUM_PADS'(RST_ZERO);
      fall_en   <= NUM_PADS'(RST_ZERO);
      status    <= NUM_PADS'(RST_ZERO);
      lock      <= 1'b0;
      irq       <= 1'b0;
      ReadValid <= 1'b0;
      ReadData  <= '0;
    end else begin
      if (WriteStrobe && !(lock && is_lock_protected(waddr))) begin
        case (waddr)
          DATA_W'(REG_OWNER):       owner   <= wdata;
          DATA_W'(REG_CPU_OUT):     cpu_out <= wdata;
          DATA_W'(REG_CPU_OE):      cpu_oe  <= wdata;
          DATA_W'(REG_IE):          ie      <= wdata;
          DATA_W'(REG_PE):          pe      <= wdata;
          DATA_W'(REG_DS):          ds      <= wdata;
          DATA_W'(REG_IRQ_RISE_EN): rise_en <= wdata;
          DATA_W'(REG_IRQ_FALL_EN): fall_en <= wdata;
          DATA_W'(REG_LOCK):        lock    <= lock | (|(WriteData & LOCK_SET_MASK));
          default: ;
        endcase
      end
      status    <= status_next;
      irq       <= |status;
      ReadValid <= ReadStrobe;
      if (ReadStrobe) ReadData <= rd_word;
    end
  end

  assign pad_I   = (owner & cpu_out) | (~owner & I_top);
  assign pad_OEN = (owner & ~cpu_oe) | (~owner & T_top);
  assign O_top   = ~owner & pad_C;
  assign pad_IE  = ie;
  assign pad_PE  = pe;
  assign pad_DS  = ds;

endmodule

// File: tb/tb_efpga_pad_ctrl.sv
// Directed plus randomized bench for efpga_pad_ctrl against an array-based
// register model; a second 4-pad instance covers narrow-width readback.
module tb_efpga_pad_ctrl;

  localparam int unsigned NP = 16;
  localparam int unsigned SS = 2;
  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic          CLK, resetn;
  logic [NP-1:0] I_top, T_top, O_top, pad_C, pad_I, pad_OEN, pad_IE, pad_PE, pad_DS;
  logic          WriteStrobe, ReadStrobe, ReadValid, irq;
  logic [3:0]    WriteAddr, ReadAddr;
  logic [31:0]   WriteData, ReadData;

  logic [3:0]    o4_top, pad4_i, pad4_oen, pad4_ie, pad4_pe, pad4_ds;
  logic [31:0]   read_data4;
  logic          read_valid4, irq4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_reg [11];

  efpga_pad_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(SS), .ADDR_W(4)) u_dut (
    .CLK(CLK), .resetn(resetn), .I_top(I_top), .T_top(T_top), .O_top(O_top),
    .pad_C(pad_C), .pad_I(pad_I), .pad_OEN(pad_OEN), .pad_IE(pad_IE),
    .pad_PE(pad_PE), .pad_DS(pad_DS), .WriteStrobe(WriteStrobe),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .ReadStrobe(ReadStrobe),
    .ReadAddr(ReadAddr), .ReadData(ReadData), .ReadValid(ReadValid), .irq(irq)
  );

  efpga_pad_ctrl #(.NUM_PADS(4), .SYNC_STAGES(SS), .ADDR_W(4)) u_dut4 (
    .CLK(CLK), .resetn(resetn), .I_top(I_top[3:0]), .T_top(T_top[3:0]), .O_top(o4_top),
    .pad_C(pad_C[3:0]), .pad_I(pad4_i), .pad_OEN(pad4_oen), .pad_IE(pad4_ie),
    .pad_PE(pad4_pe), .pad_DS(pad4_ds), .WriteStrobe(WriteStrobe),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .ReadStrobe(ReadStrobe),
    .ReadAddr(ReadAddr), .ReadData(read_data4), .ReadValid(read_valid4), .irq(irq4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 11; i++) m_reg[i] = 32'h0;
    m_reg[3] = MASK;
    m_reg[4] = MASK;
    m_reg[5] = MASK;
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (a == 9) return 32'(pad_C);
    if (a > 10) return 32'h0;
    return m_reg[a];
  endfunction

  task automatic m_write(input int a, input logic [31:0] d);
    if (a > 10 || a == 9) return;
    if (m_reg[10][0] && (a == 0 || a == 3 || a == 4 || a == 5 || a == 10)) return;
    if (a == 8)       m_reg[8] = m_reg[8] & ~d;
    else if (a == 10) m_reg[10] = m_reg[10] | {31'h0, d[0]};
    else              m_reg[a] = d & MASK;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    WriteStrobe = 1'b1;
    WriteAddr   = 4'(a);
    WriteData   = d;
    tick();
    WriteStrobe = 1'b0;
    m_write(a, d);
  endtask

  task automatic do_read(input string tag, input int a, input logic [31:0] exp);
    ReadStrobe = 1'b1;
    ReadAddr   = 4'(a);
    tick();
    ReadStrobe = 1'b0;
    check({tag, "_valid"}, 32'(ReadValid), 32'h1);
    check(tag, ReadData, exp);
  endtask

  task automatic check_pads(input string tag);
    logic [NP-1:0] own, cout, coe;
    own  = m_reg[0][NP-1:0];
    cout = m_reg[1][NP-1:0];
    coe  = m_reg[2][NP-1:0];
    check({tag, "_pad_I"},   32'(pad_I),   32'((own & cout) | (~own & I_top)));
    check({tag, "_pad_OEN"}, 32'(pad_OEN), 32'((own & ~coe) | (~own & T_top)));
    check({tag, "_O_top"},   32'(O_top),   32'(~own & pad_C));
    check({tag, "_cfg"},     {pad_IE, pad_PE}, {m_reg[3][NP-1:0], m_reg[4][NP-1:0]});
    check({tag, "_ds"},      32'(pad_DS),  m_reg[5]);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    tick();
    tick();
    m_reset();
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", ReadData, 32'h0);
    check("rst_rvalid", 32'(ReadValid), 32'h0);
    check_pads("rst");
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; WriteStrobe = 1'b0; ReadStrobe = 1'b0;
    WriteAddr = 4'h0; ReadAddr = 4'h0; WriteData = 32'h0;
    I_top = 16'($urandom); T_top = 16'($urandom); pad_C = 16'h0000;
    m_reset();

    // Reset state
    apply_reset();
    check("rst4_cfg", {28'h0, pad4_ie & pad4_pe & pad4_ds}, 32'hF);
    check("rst4_mux", {20'h0, o4_top, pad4_i, pad4_oen}, {20'h0, pad_C[3:0], I_top[3:0], T_top[3:0]});
    check("rst4_irq", {30'h0, irq4, read_valid4}, 32'h0);
    do_read("rst_owner", 0, 32'h0);
    do_read("rst_ie", 3, 32'h0000_FFFF);

    // Ownership of pad 0 by the CPU
    pad_C = 16'h0001;
    do_write(0, 32'h1);
    do_write(1, 32'h1);
    do_write(2, 32'h1);
    check("own_pad_I0", 32'(pad_I[0]), 32'h1);
    check("own_oen0", 32'(pad_OEN[0]), 32'h0);
    check("own_otop0", 32'(O_top[0]), 32'h0);
    I_top = 16'($urandom); T_top = 16'($urandom);
    #1;
    check_pads("own");
    do_write(0, 32'h0);
    pad_C = 16'h0000;
    for (int i = 0; i < 5; i++) tick();

    // Rising edge on pad 3: STATUS after SS+1 cycles, irq after SS+2
    do_write(6, 32'h8);
    pad_C = 16'h0008;
    for (int i = 0; i < int'(SS); i++) tick();
    do_read("edge_status_early", 8, 32'h0);
    check("edge_irq_early", 32'(irq), 32'h0);
    do_read("edge_status", 8, 32'h8);
    check("edge_irq", 32'(irq), 32'h1);
    m_reg[8] = 32'h8;
    do_write(8, 32'h8);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    tick();
    check("w1c_irq", 32'(irq), 32'h0);
    pad_C = 16'h0000;
    for (int i = 0; i < 5; i++) tick();
    check("fall_disabled_irq", 32'(irq), 32'h0);

    // Fall on pad 5 coincident with W1C of the same bit
    do_write(7, 32'h20);
    pad_C = 16'h0020;
    for (int i = 0; i < 5; i++) tick();
    check("rise_disabled_irq", 32'(irq), 32'h0);
    pad_C = 16'h0000;
    for (int i = 0; i < int'(SS); i++) tick();
    do_write(8, 32'h20);
    m_reg[8] = 32'h20;
    do_read("set_beats_clr", 8, 32'h20);
    check("set_beats_clr_irq", 32'(irq), 32'h1);
    do_write(8, 32'h20);
    do_read("clr_after", 8, 32'h0);

    // Read map, hold behaviour, same-cycle write+read
    pad_C = 16'hA5A5;
    for (int i = 0; i < 4; i++) tick();
    do_read("pad_in", 9, 32'h0000_A5A5);
    tick();
    check("rvalid_idle", 32'(ReadValid), 32'h0);
    check("rdata_hold", ReadData, 32'h0000_A5A5);
    do_read("unmapped15", 15, 32'h0);
    do_write(15, 32'hFFFF_FFFF);
    do_read("unmapped11", 11, 32'h0);
    WriteStrobe = 1'b1; WriteAddr = 4'd1; WriteData = 32'h0000_55AA;
    ReadStrobe = 1'b1; ReadAddr = 4'd1;
    tick();
    WriteStrobe = 1'b0; ReadStrobe = 1'b0;
    check("wr_rd_same", ReadData, m_reg[1]);
    m_write(1, 32'h0000_55AA);
    do_read("wr_rd_after", 1, 32'h0000_55AA);

    // Randomized register traffic against the model
    for (int i = 0; i < 80; i++) begin
      int a;
      logic [31:0] d;
      I_top = 16'($urandom); T_top = 16'($urandom);
      a = int'($urandom_range(0, 15));
      d = $urandom;
      if ((a == 6 || a == 7) && ($urandom_range(0, 1) == 1)) d = 32'h0;
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read("rand_read", a, m_read(a));
      check_pads("rand");
    end
    check("rand_irq", 32'(irq), 32'(m_reg[8] != 0));

    // Lock behaviour
    apply_reset();
    do_write(0, 32'h3);
    do_write(10, 32'h1);
    do_write(0, 32'hFFFF);
    do_write(3, 32'h0);
    do_read("lock_owner", 0, 32'h3);
    do_read("lock_ie", 3, 32'h0000_FFFF);
    do_write(1, 32'h0000_1234);
    do_read("lock_cpu_out", 1, 32'h0000_1234);
    do_write(10, 32'h0);
    do_read("lock_sticky", 10, 32'h1);
    check_pads("lock");

    // Mid-operation reset with pad_C high: warm-up masks spurious edges
    pad_C = 16'hA5A5;
    apply_reset();
    do_write(6, 32'hFFFF);
    do_write(7, 32'hFFFF);
    for (int i = 0; i < 4; i++) tick();
    check("warm_irq", 32'(irq), 32'h0);
    do_read("warm_status", 8, 32'h0);
    do_read("rst_lock", 10, 32'h0);
    do_read("rst_owner2", 0, 32'h0);

    // Narrow instance: bits above NUM_PADS read 0
    do_write(1, 32'hFFFF_FFFF);
    do_read("wide_cpu_out", 1, 32'h0000_FFFF);
    check("np4_cpu_out", read_data4, 32'h0000_000F);
    check("np4_valid", 32'(read_valid4), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
